// File: rtl/and16_result_buffer.sv
// Two-entry registered result buffer behind the And16 stage, carrying Hack zr/ng status flags.
// Latency: one cycle from push to out_valid_o. There is no same-cycle bypass.
// Backpressure: absorbs one stalled cycle. in_ready_o is a decode of the registered count only.
module and16_result_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic [1:0]       count_o
);

    // The state encoding is the occupancy, so count_o is the state register itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_head_dat;
    logic             r_head_zr;
    logic             r_head_ng;
    logic [WIDTH-1:0] r_tail_dat;
    logic             r_tail_zr;
    logic             r_tail_ng;

    logic             w_push;
    logic             w_pop;
    logic             w_load_head_in;
    logic             w_load_head_tail;
    logic             w_load_tail;
    logic             w_in_zr;
    logic             w_in_ng;

    assign w_in_zr     = ~|data_i;
    assign w_in_ng     = data_i[WIDTH-1];

    assign in_ready_o  = (r_state != ST_FULL);
    assign out_valid_o = (r_state != ST_EMPTY);
    assign count_o     = r_state;

    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = out_valid_o && out_ready_i;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_head_in   = 1'b0;
        w_load_head_tail = 1'b0;
        w_load_tail      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_load_head_in = 1'b1;
                    w_state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_load_head_in = 1'b1;
                end else if (w_push) begin
                    w_load_tail = 1'b1;
                    w_state_nxt = ST_FULL;
                end else if (w_pop) begin
                    // Head keeps its stale contents; out_valid_o marks them invalid.
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_load_head_tail = 1'b1;
                    w_state_nxt      = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_head_dat <= '0;
            r_head_zr  <= 1'b1;
            r_head_ng  <= 1'b0;
        end else if (w_load_head_in) begin
            r_head_dat <= data_i;
            r_head_zr  <= w_in_zr;
            r_head_ng  <= w_in_ng;
        end else if (w_load_head_tail) begin
            r_head_dat <= r_tail_dat;
            r_head_zr  <= r_tail_zr;
            r_head_ng  <= r_tail_ng;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tail_dat <= '0;
            r_tail_zr  <= 1'b1;
            r_tail_ng  <= 1'b0;
        end else if (w_load_tail) begin
            r_tail_dat <= data_i;
            r_tail_zr  <= w_in_zr;
            r_tail_ng  <= w_in_ng;
        end
    end

    assign data_o = r_head_dat;
    assign zr_o   = r_head_zr;
    assign ng_o   = r_head_ng;

endmodule

// File: doc/and16_result_buffer.md
# and16_result_buffer

Registered 2-entry output buffer that sits directly downstream of the 16-bit bitwise AND stage (`And16`). It captures each result word with a valid/ready handshake and presents it to the next stage, which is the ALU flag logic or a register write port. Alongside each word it registers Hack-style status flags: zero (`zr`) and negative (`ng`). It cuts the combinational path from the AND array to the consumer and absorbs one cycle of consumer back-pressure without loss.

## Interface
- `WIDTH`, 16: data word width. Flags assume the MSB is the sign bit.
- `clk_i`  input  1  rising-edge clock.
- `rst_n_i`  input  1  asynchronous, active-low reset.
- `in_valid_i`  input  1  producer has a result on `data_i`.
- `in_ready_o`  output  1  buffer can accept a word this cycle.
- `data_i`  input  WIDTH  result word from the AND stage.
- `out_valid_o`  output  1  head entry is valid.
- `out_ready_i`  input  1  consumer accepts the head this cycle.
- `data_o`  output  WIDTH  head entry data.
- `zr_o`  output  1  head data == 0.
- `ng_o`  output  1  head data[WIDTH-1].
- `count_o`  output  2  occupancy, 0..2.

## Operation
- Storage: two entries, `head` and `tail`. Each entry holds {data, zr, ng}. Flags are computed from `data_i` at enqueue and stored; they are never recomputed from `data_o`.
- Push = `in_valid_i && in_ready_o`. Pop = `out_valid_o && out_ready_i`.
- `in_ready_o` = (count < 2). It is derived from registered count only, with no combinational path from `out_ready_i`.
- `out_valid_o` = (count != 0).
- State is the occupancy count:
  - **EMPTY (0)**:
    - push → head := input; ONE.
    - pop is impossible.
  - **ONE (1)**:
    - push only → tail := input; FULL.
    - pop only → EMPTY. Head contents are retained but invalid.
    - push+pop → head := input; stays ONE.
  - **FULL (2)**:
    - push is impossible because `in_ready_o` = 0.
    - pop → head := tail; ONE.
- Order is strictly FIFO. No word is dropped or duplicated.
- `data_o`/`zr_o`/`ng_o` hold their last values while `out_valid_o` = 0. Consumers must ignore them.
- Inputs asserted while `in_ready_o` = 0 are ignored with no side effects.
- `WIDTH` arithmetic: `zr` is a WIDTH-bit NOR reduction. `count_o` never exceeds 2.

## Timing
- Reset (`rst_n_i` low, asynchronous, effective immediately and independent of `clk_i`):
  - count = 0
  - `out_valid_o` = 0
  - `in_ready_o` = 1
  - `data_o` = 0
  - `zr_o` = 1
  - `ng_o` = 0
  - tail = 0
- Reset release: the first push can occur at the first rising edge after `rst_n_i` goes high.
- Reset mid-operation: all buffered entries are discarded at once, with no partial pop.
- Latency: a word pushed at edge N appears on `data_o` with `out_valid_o` = 1 after edge N (1 cycle). There is no same-cycle bypass.
- Throughput: one word per cycle sustained when `out_ready_i` is held high (state stays ONE).
- Back-pressure:
  - At ONE with `out_ready_i` = 0, a push moves the buffer to FULL, and `in_ready_o` falls after that edge.
  - The first pop from FULL raises `in_ready_o` after that edge.
- All outputs are registers, or decodes of the registered count.

## Test plan
- **Reset values:** hold `rst_n_i` = 0 and toggle inputs → `count_o`=0, `out_valid_o`=0, `in_ready_o`=1, `data_o`=0x0000, `zr_o`=1, `ng_o`=0.
- **Single transfer with flags:**
  - Push 0x2AA0 (0xAAAA & 0x3BF1), `out_ready_i`=1 → next cycle `data_o`=0x2AA0, `zr_o`=0, `ng_o`=0, valid for exactly 1 cycle.
  - Push 0x0000 → `zr_o`=1.
  - Push 0x8000 → `ng_o`=1.
- **Fill and drain:**
  - `out_ready_i`=0, push 0xFFFF then 0x0000 → `count_o`=2, `in_ready_o`=0, `data_o`=0xFFFF, `ng_o`=1.
  - A third `in_valid_i` (0x1234) is ignored.
  - Raise `out_ready_i` → outputs 0xFFFF, then 0x0000 (`zr_o`=1), then `out_valid_o`=0. 0x1234 never appears.
- **Simultaneous push+pop at ONE:** with head = 0x00FF, push 0xF00F with `out_ready_i`=1 → `count_o` stays 1, `data_o`=0xF00F, `ng_o`=1.
- **Streaming:** 8 back-to-back pushes 0x0001..0x0008 with random `out_ready_i` → consumer receives exactly 0x0001..0x0008 in order, and `count_o` never exceeds 2.
- **Reset mid-operation:** at FULL, pulse `rst_n_i` low between clock edges → outputs go to reset values immediately. After release, push 0x5555 → `data_o`=0x5555 one cycle later with `count_o`=1.
